// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry, memory FSM state and
// the forward-select width helper.
package hazard_pkg;

    // Widest register index any instance may use; narrower indices are zero-extended.
    localparam int unsigned REG_W_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_MAX-1:0] rd;
        logic                 wr;
        logic                 load;
        logic                 mem;
    } sb_entry_t;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } mem_state_e;

    function automatic int unsigned fwd_w(int unsigned nstage);
        return $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side and data-memory signals exchanged with the hazard controller.
interface hazard_ctrl_if #(
    parameter int unsigned NSTAGE          = 2,
    parameter int unsigned REG_INDEX_WIDTH = 5
);
    localparam int unsigned FWD_W = hazard_pkg::fwd_w(NSTAGE);

    logic                       id_valid;
    logic [REG_INDEX_WIDTH-1:0] id_rs1;
    logic [REG_INDEX_WIDTH-1:0] id_rs2;
    logic                       id_rs1_used;
    logic                       id_rs2_used;
    logic [REG_INDEX_WIDTH-1:0] id_rd;
    logic                       id_reg_wr;
    logic                       id_is_load;
    logic                       id_is_store;
    logic                       br_taken;
    logic                       mem_ready;
    logic                       pc_en;
    logic                       fd_en;
    logic                       fd_flush;
    logic                       bubble;
    logic                       mem_req;
    logic [FWD_W-1:0]           fwd_a;
    logic [FWD_W-1:0]           fwd_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_wr,
               id_is_load, id_is_store, br_taken, mem_ready,
        input  pc_en, fd_en, fd_flush, bubble, mem_req, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_wr,
               id_is_load, id_is_store, br_taken, mem_ready,
        output pc_en, fd_en, fd_flush, bubble, mem_req, fwd_a, fwd_b
    );

endinterface

// File: rtl/hazard_match.sv
// Per-source scoreboard search: nearest in-flight writer gives the forward select, or a
// load-use hazard when that writer is a load whose data is not yet forwardable.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned NSTAGE          = 2,
    parameter int unsigned LOAD_STAGE      = 2,
    parameter int unsigned REG_INDEX_WIDTH = 5,
    localparam int unsigned FWD_W          = fwd_w(NSTAGE)
) (
    input  sb_entry_t [NSTAGE-1:0]      sb,
    input  logic [REG_INDEX_WIDTH-1:0]  rs,
    input  logic                        rs_used,
    output logic [FWD_W-1:0]            fwd,
    output logic                        load_use
);

    logic [REG_W_MAX-1:0] rs_ext;
    logic                 found;
    logic                 unused_mem;

    assign rs_ext = REG_W_MAX'(rs);

    always_comb begin
        fwd        = '0;
        load_use   = 1'b0;
        found      = 1'b0;
        unused_mem = 1'b0;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            unused_mem = unused_mem ^ sb[k].mem;
            // Array index k holds pipeline stage k+1; the first hit is the youngest writer.
            if (!found && rs_used && (rs_ext != '0) && sb[k].valid && sb[k].wr &&
                (sb[k].rd == rs_ext)) begin
                found = 1'b1;
                if (sb[k].load && ((k + 1) < LOAD_STAGE)) begin
                    load_use = 1'b1;
                end else begin
                    fwd = FWD_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboard, forwarding, load-use stall, branch flush, memory wait.
// Optional HAZARD_CTRL_PERF_EN adds saturating stall/flush/mem-wait counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NSTAGE          = 2,  // 1..4
    parameter int unsigned LOAD_STAGE      = 2,  // 1..NSTAGE
    parameter int unsigned REG_INDEX_WIDTH = 5
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] mem_wait_cycles
`endif
);

    localparam int unsigned FWD_W = fwd_w(NSTAGE);

    sb_entry_t [NSTAGE-1:0] sb_q, sb_d;
    mem_state_e             state_q, state_d;
    sb_entry_t              new_entry;

    logic [FWD_W-1:0] fwd_a_raw, fwd_b_raw;
    logic             lu_a, lu_b;
    logic             mem_req, mem_stall, load_stall, br_flush;
    logic             pc_en, fd_en, fd_flush, bubble, advance;

    hazard_match #(
        .NSTAGE          (NSTAGE),
        .LOAD_STAGE      (LOAD_STAGE),
        .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
    ) u_match_a (
        .sb       (sb_q),
        .rs       (bus.id_rs1),
        .rs_used  (bus.id_rs1_used),
        .fwd      (fwd_a_raw),
        .load_use (lu_a)
    );

    hazard_match #(
        .NSTAGE          (NSTAGE),
        .LOAD_STAGE      (LOAD_STAGE),
        .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
    ) u_match_b (
        .sb       (sb_q),
        .rs       (bus.id_rs2),
        .rs_used  (bus.id_rs2_used),
        .fwd      (fwd_b_raw),
        .load_use (lu_b)
    );

    always_comb begin
        new_entry       = '0;
        new_entry.valid = bus.id_valid;
        new_entry.rd    = REG_W_MAX'(bus.id_rd);
        new_entry.wr    = bus.id_reg_wr;
        new_entry.load  = bus.id_is_load;
        new_entry.mem   = bus.id_is_load | bus.id_is_store;

        mem_req    = (state_q == StWait) || (sb_q[0].valid && sb_q[0].mem);
        mem_stall  = mem_req && !bus.mem_ready;
        load_stall = bus.id_valid && (lu_a || lu_b);
        br_flush   = bus.id_valid && bus.br_taken;

        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b0;
        bubble   = 1'b0;
        advance  = 1'b1;
        if (mem_stall) begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            advance = 1'b0;
        end else if (load_stall) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            bubble = 1'b1;
        end else if (br_flush) begin
            fd_flush = 1'b1;
        end

        state_d = state_q;
        case (state_q)
            StIdle:  if (mem_stall) state_d = StWait;
            StWait:  if (bus.mem_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        sb_d = sb_q;
        if (advance) begin
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0]       = new_entry;
            sb_d[0].valid = bus.id_valid && !bubble;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q    <= '0;
            state_q <= StIdle;
        end else begin
            sb_q    <= sb_d;
            state_q <= state_d;
        end
    end

    // Reset forces a flushing, bubbling, free-running front end.
    assign bus.pc_en    = reset | pc_en;
    assign bus.fd_en    = reset | fd_en;
    assign bus.fd_flush = reset | fd_flush;
    assign bus.bubble   = reset | bubble;
    assign bus.mem_req  = !reset & mem_req;
    assign bus.fwd_a    = reset ? '0 : fwd_a_raw;
    assign bus.fwd_b    = reset ? '0 : fwd_b_raw;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q, wait_q;
    logic        stall_ev, flush_ev, wait_ev;

    assign stall_ev = !mem_stall && load_stall;
    assign flush_ev = !mem_stall && !load_stall && br_flush;
    assign wait_ev  = (state_q == StWait);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
            wait_q  <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (flush_ev && (flush_q != '1)) flush_q <= flush_q + 32'd1;
            if (wait_ev && (wait_q != '1))   wait_q  <= wait_q + 32'd1;
        end
    end

    assign stall_cycles    = stall_q;
    assign flush_count     = flush_q;
    assign mem_wait_cycles = wait_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the RV32I core, generalising the current single-stage forwarding/flush logic to a pipeline with `NSTAGE` result-holding stages after decode. It keeps a registered scoreboard of in-flight destination registers and produces the pipeline control signals:

- forwarding selects;
- load-use stalls with bubble insertion;
- branch flushes;
- stall-while-busy on a variable-latency data memory req/ready handshake.

It sits beside the decode stage and drives PC enable, the F/D register enables and the stage-1 bubble.

## Interface
Parameters:
- `NSTAGE`, 2: stages after decode that hold a register result (1 reproduces the 3-stage core); legal range 1..4.
- `LOAD_STAGE`, 2: first stage index at which load data is forwardable; legal range 1..`NSTAGE`.
- `REG_INDEX_WIDTH`, 5: register index width.

Ports (`FWD_W` = `$clog2(NSTAGE+1)`):
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: decode holds a valid instruction.
- `id_rs1`, `id_rs2` in `REG_INDEX_WIDTH`: source registers.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in `REG_INDEX_WIDTH`: destination register.
- `id_reg_wr` in 1: the instruction writes `id_rd`.
- `id_is_load`, `id_is_store` in 1: memory operation class.
- `br_taken` in 1: branch/jump resolved taken in decode.
- `mem_ready` in 1: data memory completes the current request this cycle.
- `pc_en` out 1: PC update enable.
- `fd_en` out 1: F/D register enable.
- `fd_flush` out 1: clear the F/D instruction to NOP.
- `bubble` out 1: stage 1 loads a NOP instead of the decode instruction.
- `mem_req` out 1: stage 1 holds a memory op awaiting completion.
- `fwd_a`, `fwd_b` out `FWD_W`: 0 selects the register file; k selects the stage-k result.

## Operation
- Scoreboard: `NSTAGE` entries {valid, rd, wr, load, mem}. Entry k mirrors pipeline stage k.
- Advance when not mem-stalled:
  - entry k+1 <= entry k;
  - entry 1 <= the decode instruction, or invalid if `bubble`;
  - entry `NSTAGE` retires.
- Forwarding, per source:
  - Search for the smallest k whose entry has valid & wr & rd==rs & rs!=0.
  - If entry k is a load and k < `LOAD_STAGE`: this is a load-use hazard.
  - Otherwise fwd=k. No match gives fwd=0.
  - An unused source or x0 always gives fwd=0 and never stalls.
- Load-use stall: `pc_en`=0, `fd_en`=0, `bubble`=1; the scoreboard still advances.
- Memory FSM:
  - IDLE:
    - `mem_req` = entry1.valid & entry1.mem.
    - If `mem_req` & !`mem_ready` -> WAIT.
  - WAIT:
    - `mem_req`=1.
    - `pc_en`=`fd_en`=0, `bubble`=0; the scoreboard is frozen.
    - On `mem_ready` -> IDLE, and the pipeline advances that same cycle.
- Branch: `br_taken` & `id_valid` with no stall gives `fd_flush`=1 and `pc_en`=1. The branch instruction itself enters stage 1.
- Priority, highest first:
  1. reset
  2. mem stall
  3. load-use stall
  4. branch flush
  5. normal

  A stalled branch is re-evaluated when the stall releases; `br_taken` during a stall is ignored.
- Reset mid-WAIT: the FSM returns to IDLE and the request is abandoned.

## Timing
- All hazard outputs are combinational from the registered scoreboard/FSM plus decode inputs; zero-cycle decision latency.
- Scoreboard and FSM update on the `clk` rising edge.
- Load-use penalty: (`LOAD_STAGE` − k) bubbles, where k is the stage of the matching load.
- Memory penalty: one frozen cycle per cycle that `mem_ready` is low.
- While `reset`=1: `pc_en`=1, `fd_en`=1, `fd_flush`=1, `bubble`=1, `mem_req`=0, `fwd_a`=`fwd_b`=0.
- First cycle after reset: scoreboard all-invalid, FSM IDLE, all outputs at normal-flow values.

## Configuration
- `HAZARD_CTRL_PERF_EN`:
  - Defined: adds the outputs `stall_cycles`, `flush_count`, `mem_wait_cycles` (32 bits each).
    - They clear on reset, increment on load-use-stall cycles, flush cycles and WAIT cycles respectively, and saturate at all-ones.
  - Undefined: the ports and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `hazard_pkg`:
  - the scoreboard entry struct type;
  - the FSM state enum (IDLE, WAIT);
  - the `FWD_W` helper function.
- One sub-module, `hazard_match`: combinational per-source search returning {fwd, load_use}. It is instantiated twice (rs1, rs2).

## Test plan
- `NSTAGE`=2, `LOAD_STAGE`=2:
  - `addi x5` followed by `add x6,x5,x5` -> `fwd_a`=`fwd_b`=1.
  - One cycle later, a reader of x5 -> fwd=2.
- `lw x7` followed immediately by `add x8,x7,x0` -> one cycle with `bubble`=1, `pc_en`=0; next cycle `fwd_a`=2, `fwd_b`=0.
- Writer to x0 followed by a reader of x0 -> fwd=0, no stall.
- `sw` in stage 1 with `mem_ready` low for 3 cycles -> `mem_req`=1 for 4 cycles and `pc_en`=0 for 3; the scoreboard advances on the 4th.
- `br_taken`=1 in the same cycle as a load-use hazard -> stall only, `fd_flush`=0. The next cycle with `br_taken`=1 -> `fd_flush`=1.
- `reset` asserted during WAIT -> next cycle FSM IDLE, `mem_req`=0, all fwd=0. With `HAZARD_CTRL_PERF_EN`, all counters read 0.
